fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Receiving end of the instruction-fetch interface: a small first-word-fall-through queue that accepts (PC, Instruction) pairs from the IF stage and presents them to the ID stage. It decouples fetch from decode stalls. It drives `freeze` back to IF when full and discards all queued (wrong-path) instructions when `Branch_Tacken` is asserted. It sits between the IF stage and the IF/ID boundary of the pipelined datapath.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2
- `WIDTH`, 32, instruction and PC width in bits
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  IF presents a fetched instruction this cycle
- `in_pc`  in  WIDTH  PC+4 value associated with the instruction
- `in_instr`  in  WIDTH  fetched instruction word
- `freeze`  out  1  to IF: queue full, hold PC; push not accepted
- `Branch_Tacken`  in  1  flush: discard queue contents and this cycle's input
- `pop`  in  1  ID consumes the head entry this cycle
- `out_valid`  out  1  head entry valid
- `out_pc`  out  WIDTH  head PC; 0 when empty
- `Instruction`  out  WIDTH  head instruction; NOP (32'b0) when empty
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH × (2·WIDTH) register array; write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` register 0..DEPTH.
- push = `in_valid & ~freeze & ~Branch_Tacken`; writes `{in_pc,in_instr}` at `wr_ptr`, `wr_ptr`++.
- do_pop = `pop & out_valid & ~Branch_Tacken`; `rd_ptr`++. Pop when empty is ignored (no pointer or count change).
- count next: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: count == DEPTH → `freeze`=1. Push is refused even if pop occurs in the same cycle. `freeze` is a function of registered count only (no combinational path from `pop`).
- Empty, push and pop in the same cycle: pop is ignored (out_valid=0), push accepted; the entry appears the next cycle.
- Flush (`Branch_Tacken`=1) has priority over push and pop: next cycle count=0, wr_ptr=rd_ptr=0, out_valid=0. Array contents need not be cleared.
- Outputs are combinational reads of registered state: out_valid = (count≠0); out_pc/Instruction = array[rd_ptr] when valid, else 0 / NOP.
- Ordering: strictly FIFO; no reordering, no duplication, no loss except on flush.

## Timing
- Reset (async assert, sync-to-clk release): count=0, pointers=0, out_valid=0, freeze=0, out_pc=0, Instruction=0, all array entries=0.
- Reset mid-operation discards all entries identically to flush, without waiting for a clock edge.
- Push→visible latency: 1 cycle (entry written at edge N is at head at N+1 if queue was empty).
- Pop→next head: 1 cycle.
- freeze asserts in the cycle after the push that makes count==DEPTH. It deasserts in the cycle after the first pop from full.
- Flush takes effect at the next edge; the instruction presented in the flush cycle is never stored.
- Sustained throughput: 1 push + 1 pop per cycle when 0<count<DEPTH.

## Structure
- Shared package `cpu_pkg`: `INSTR_W`=32, `ADDR_W`=32, `NOP_INSTR`=32'b0, and a packed `fetch_entry_t` {pc, instr}.
- One natural sub-module: `prefetch_mem`, the DEPTH-entry register array with write port and async read port, reset to zero.
- Pointer/count logic and flush priority stay in the top module.

## Test plan
- Reset: assert rst for 52 ns mid-run with 2 entries queued → out_valid=0, count=0, Instruction=0, freeze=0 immediately. After release, first push is observed at head.
- Fill: push 0xE3A00001..0xE3A00004 with pop=0 → count=4, freeze=1 after 4th edge. A 5th instruction held at input is not stored. Pops return the 4 words in order.
- Streaming: in_valid=1 and pop=1 every cycle for 20 cycles with incrementing PCs 4,8,... → count stays at 1, output PCs are consecutive, no gaps.
- Flush: queue holds 3 entries, Branch_Tacken=1 with in_valid=1 and pop=1 → next cycle count=0, out_valid=0. The flush-cycle input never appears. The next push lands at pointer 0.
- Full with simultaneous pop: count=4, pop=1, in_valid=1 → count=3, freeze=0 next cycle, input not accepted that cycle.
- Wrap: 10 push/pop cycles at count between 1 and 3 → pointers wrap past DEPTH−1 with FIFO order preserved. Empty-pop with pop=1 leaves count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction/address widths, the decode NOP and the
// fetch queue entry layout.
`timescale 1ns/1ps
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/prefetch_mem.sv
// Register array backing the prefetch queue: one synchronous write port and one
// asynchronous read port; every entry clears on reset.
`timescale 1ns/1ps
module prefetch_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [DEPTH-1:0][W-1:0] mem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_prefetch_queue.sv
// First-word-fall-through queue between IF and ID. Holds (PC, instruction)
// pairs, back-pressures fetch via freeze and drops everything on a taken branch.
`timescale 1ns/1ps
module fetch_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     freeze,
    input  logic                     Branch_Tacken,
    input  logic                     pop,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         Instruction,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push;
    logic               do_pop;
    logic [2*WIDTH-1:0] rd_entry;

    // Derived from registered occupancy only, so pop never reaches freeze combinationally.
    assign freeze    = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push   = in_valid & ~freeze & ~Branch_Tacken;
    assign do_pop = pop & out_valid & ~Branch_Tacken;

    prefetch_mem #(
        .DEPTH (DEPTH),
        .W     (2*WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc, in_instr}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Branch_Tacken) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !do_pop)      count_d = count_q + 1'b1;
            else if (!push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_pc      = out_valid ? rd_entry[2*WIDTH-1:WIDTH] : '0;
    assign Instruction = out_valid ? rd_entry[WIDTH-1:0] : WIDTH'(NOP_INSTR);
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed scenarios plus random traffic
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_pc = '0;
    logic [WIDTH-1:0] in_instr = '0;
    logic             freeze;
    logic             Branch_Tacken = 1'b0;
    logic             pop = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] Instruction;
    logic [$clog2(DEPTH):0] count;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .freeze        (freeze),
        .Branch_Tacken (Branch_Tacken),
        .pop           (pop),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .Instruction   (Instruction),
        .count         (count)
    );

    always #5 clk = ~clk;

    fetch_entry_t model_q[$];
    fetch_entry_t exp_q[$];
    int           checks = 0;
    int           failures = 0;
    bit           chk_en = 1'b0;
    int           cur_cnt = 0;
    fetch_entry_t cur_head;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the model advances to the state after the coming edge.
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit p, input bit fl);
        fetch_entry_t e;
        bit do_p;
        bit do_w;
        @(posedge clk);
        #1;
        cur_cnt = model_q.size();
        cur_head = (cur_cnt != 0) ? model_q[0] : '0;
        in_valid = v;
        in_pc = pc;
        in_instr = ins;
        pop = p;
        Branch_Tacken = fl;
        chk_en = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            do_p = p && (cur_cnt > 0);
            do_w = v && (cur_cnt < DEPTH);
            if (do_p) exp_q.push_back(model_q.pop_front());
            if (do_w) begin
                e.pc = pc;
                e.instr = ins;
                model_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        fetch_entry_t e;
        if (chk_en && !rst) begin
            chk("count", 64'(count), 64'(cur_cnt));
            chk("freeze", 64'(freeze), 64'(cur_cnt == DEPTH));
            chk("out_valid", 64'(out_valid), 64'(cur_cnt != 0));
            chk("head_pc", 64'(out_pc), 64'(cur_head.pc));
            chk("head_instr", 64'(Instruction), 64'(cur_head.instr));
            if (pop && out_valid && !Branch_Tacken) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", 64'(out_pc), 64'(e.pc));
                    chk("pop_instr", 64'(Instruction), 64'(e.instr));
                end
            end
            chk("missed_pop", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    end

    task automatic idle();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_freeze", 64'(freeze), 64'(0));
        chk("rst_instr", 64'(Instruction), 64'(0));
        chk("rst_pc", 64'(out_pc), 64'(0));
        #13 rst = 1'b0;

        // Reset mid-run with two entries queued
        cycle(1'b1, 32'h4, 32'hAAAA0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h8, 32'hAAAA0002, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        in_valid = 1'b0;
        pop = 1'b0;
        chk("pre_rst_count", 64'(count), 64'(2));
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_instr", 64'(Instruction), 64'(0));
        chk("midrst_freeze", 64'(freeze), 64'(0));
        #51 rst = 1'b0;
        model_q.delete();
        cycle(1'b1, 32'h100, 32'hBBBB0001, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Fill, refuse a held fifth word, drain in order
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(4*i), 32'hE3A00000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h14, 32'hE3A00005, 1'b0, 1'b0);
        cycle(1'b1, 32'h14, 32'hE3A00005, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming
        for (int i = 1; i <= 20; i++) cycle(1'b1, 32'(4*i), 32'hC0DE0000 + 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Flush with three queued, then next push
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(4*i), 32'hF1000000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h2FC, 32'hDEADBEEF, 1'b1, 1'b1);
        cycle(1'b1, 32'h300, 32'h12345678, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Full with simultaneous pop and push
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400 + 32'(4*i), 32'h5A000000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h410, 32'h5A0000FF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Empty pop
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Random traffic, includes pointer wrap and occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        chk("final_empty", 64'(count), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
